// File: rtl/id_decode_reg.sv
// -----------------------------------------------------------------------------
// id_decode_reg
//
// Decode-stage front end between the IF/ID boundary and the immediate
// generator / register-file read. It accepts fetched instructions over a
// valid/ready handshake. It classifies the opcode into the 3-bit
// immediate-format select and flags illegal encodings. Decode results are
// registered into an ID output stage that supports stall and flush.
//
// After an illegal instruction is accepted, a two-state trap FSM
// (RUN / TRAP_WAIT) blocks further intake until trap_ack or flush arrives.
//
// Optional feature macro: RV32F_R4_DECODE_EN
//   defined   : FMADD/FMSUB/FNMSUB/FNMADD decode legal, ext_sel 101, rs3 valid
//   undefined : those opcodes are illegal; out_rs3 is always 0
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready     fetch-side handshake
//   in_instr, in_pc       fetched instruction and its PC
//   out_valid/out_ready   EX-side handshake
//   out_instr, out_pc     registered instruction / PC
//   out_ext_sel           immediate-format select (000 I, 001 S, 010 B, 011 J,
//                         100 U, 101 R4, 111 none)
//   out_rs1/rs2/rd/rs3    register indices (rs3 is 0 unless R4)
//   out_illegal           registered instruction is illegal
//   flush                 kill held and incoming instruction
//   trap_ack              trap handler has taken the illegal instruction
// -----------------------------------------------------------------------------
module id_decode_reg #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_ext_sel,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs3,
  output logic            out_illegal,
  input  logic            flush,
  input  logic            trap_ack
);

  localparam logic [2:0] FMT_I    = 3'b000;
  localparam logic [2:0] FMT_S    = 3'b001;
  localparam logic [2:0] FMT_B    = 3'b010;
  localparam logic [2:0] FMT_J    = 3'b011;
  localparam logic [2:0] FMT_U    = 3'b100;
`ifdef RV32F_R4_DECODE_EN
  localparam logic [2:0] FMT_R4   = 3'b101;
`endif
  localparam logic [2:0] FMT_NONE = 3'b111;

  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

  typedef enum logic {ST_RUN = 1'b0, ST_TRAP_WAIT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            xfer;

  logic [2:0]      dec_ext_sel;
  logic            dec_illegal;
  logic [4:0]      dec_rs3;

  logic            out_valid_q,   out_valid_d;
  logic [XLEN-1:0] out_instr_q,   out_instr_d;
  logic [XLEN-1:0] out_pc_q,      out_pc_d;
  logic [2:0]      out_ext_sel_q, out_ext_sel_d;
  logic [4:0]      out_rs3_q,     out_rs3_d;
  logic            out_illegal_q, out_illegal_d;

  // Opcode classification of the incoming instruction.
  always_comb begin
    dec_ext_sel = FMT_NONE;
    dec_illegal = 1'b0;
    dec_rs3     = 5'd0;
    case (in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0001111:             dec_ext_sel = FMT_I;
      7'b0100011:                         dec_ext_sel = FMT_S;
      7'b1100011:                         dec_ext_sel = FMT_B;
      7'b1101111:                         dec_ext_sel = FMT_J;
      7'b0110111, 7'b0010111:             dec_ext_sel = FMT_U;
      7'b0110011:                         dec_ext_sel = FMT_NONE;
`ifdef RV32F_R4_DECODE_EN
      7'b1000011, 7'b1000111,
      7'b1001011, 7'b1001111: begin
        dec_ext_sel = FMT_R4;
        dec_rs3     = in_instr[31:27];
      end
`endif
      default:                            dec_illegal = 1'b1;
    endcase
    // Compressed / non-32-bit encodings are never accepted. Every listed
    // opcode ends in 2'b11, so this only restates the rule explicitly.
    if (in_instr[1:0] != 2'b11) dec_illegal = 1'b1;
    if (dec_illegal) begin
      dec_ext_sel = FMT_NONE;
      dec_rs3     = 5'd0;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:       if (xfer && dec_illegal) state_d = ST_TRAP_WAIT;
      ST_TRAP_WAIT: if (trap_ack || flush)   state_d = ST_RUN;
      default:                               state_d = ST_RUN;
    endcase
  end

  // FSM: outputs. A flush this cycle always blocks intake.
  always_comb begin
    in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready) && !flush;
  end

  assign xfer = in_valid && in_ready;

  // Output register next-state, in priority order: flush, transfer, drain.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    out_ext_sel_d = out_ext_sel_q;
    out_rs3_d     = out_rs3_q;
    out_illegal_d = out_illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (xfer) begin
      out_valid_d   = 1'b1;
      out_instr_d   = in_instr;
      out_pc_d      = in_pc;
      out_ext_sel_d = dec_ext_sel;
      out_rs3_d     = dec_rs3;
      out_illegal_d = dec_illegal;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_instr_q   <= NOP_INSTR;
      out_pc_q      <= RESET_PC;
      out_ext_sel_q <= FMT_I;
      out_rs3_q     <= 5'd0;
      out_illegal_q <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      out_ext_sel_q <= out_ext_sel_d;
      out_rs3_q     <= out_rs3_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign out_ext_sel = out_ext_sel_q;
  assign out_illegal = out_illegal_q;
  assign out_rs3     = out_rs3_q;
  // The indices are raw fields of the held instruction. Downstream logic
  // decides which of them are meaningful based on ext_sel.
  assign out_rs1     = out_instr_q[19:15];
  assign out_rs2     = out_instr_q[24:20];
  assign out_rd      = out_instr_q[11:7];

endmodule

// File: tb/tb_id_decode_reg.sv
module tb_id_decode_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_instr = 32'h13, in_pc = 32'h0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_instr, out_pc;
  logic [2:0]  out_ext_sel;
  logic [4:0]  out_rs1, out_rs2, out_rd, out_rs3;
  logic        out_illegal;
  logic        flush = 1'b0, trap_ack = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  id_decode_reg dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .out_ext_sel(out_ext_sel),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_rs3(out_rs3),
    .out_illegal(out_illegal),
    .flush(flush), .trap_ack(trap_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference format table, indexed by opcode; -1 marks an illegal opcode.
  int fmt_tab[128];
  logic [6:0] legal_ops[$];

  function automatic int ref_fmt(input logic [31:0] ins);
    if (ins[1:0] != 2'b11) return -1;
    return fmt_tab[ins[6:0]];
  endfunction

  // Reference model state
  logic        m_valid, m_ill, m_trap;
  logic [31:0] m_instr, m_pc;
  logic [2:0]  m_ext;
  logic [4:0]  m_rs3;

  logic [31:0] stream_i [4];
  logic [2:0]  stream_e [4];

  initial begin
    for (int i = 0; i < 128; i++) fmt_tab[i] = -1;
    fmt_tab[7'b0010011] = 0; fmt_tab[7'b0000011] = 0; fmt_tab[7'b1100111] = 0;
    fmt_tab[7'b1110011] = 0; fmt_tab[7'b0001111] = 0;
    fmt_tab[7'b0100011] = 1;
    fmt_tab[7'b1100011] = 2;
    fmt_tab[7'b1101111] = 3;
    fmt_tab[7'b0110111] = 4; fmt_tab[7'b0010111] = 4;
    fmt_tab[7'b0110011] = 7;
`ifdef RV32F_R4_DECODE_EN
    fmt_tab[7'b1000011] = 5; fmt_tab[7'b1000111] = 5;
    fmt_tab[7'b1001011] = 5; fmt_tab[7'b1001111] = 5;
`endif
    legal_ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h6F,
                  7'h37, 7'h17, 7'h33, 7'h43, 7'h47, 7'h4B, 7'h4F};

    stream_i = '{32'h00112223, 32'h00208463, 32'h008000EF, 32'h123450B7};
    stream_e = '{3'b001, 3'b010, 3'b011, 3'b100};

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_illegal", out_illegal, 0);
    chk("rst_instr", out_instr, 32'h13);
    chk("rst_pc", out_pc, 0);
    chk("rst_ext", out_ext_sel, 0);
    chk("rst_rs", {out_rs1, out_rs2, out_rd, out_rs3}, 0);
    chk("rst_ready", in_ready, 1);

    // addi x1,x0,5
    in_valid = 1; in_instr = 32'h00500093; in_pc = 32'h100; out_ready = 1;
    @(negedge clk);
    chk("addi_valid", out_valid, 1);
    chk("addi_ext", out_ext_sel, 0);
    chk("addi_rd", out_rd, 1);
    chk("addi_rs1", out_rs1, 0);
    chk("addi_ill", out_illegal, 0);
    chk("addi_pc", out_pc, 32'h100);

    // Back-to-back stream
    for (int i = 0; i < 4; i++) begin
      in_instr = stream_i[i]; in_pc = 32'h104 + 4 * i;
      #1 chk("stream_ready", in_ready, 1);
      @(negedge clk);
      chk("stream_ext", out_ext_sel, stream_e[i]);
      chk("stream_instr", out_instr, stream_i[i]);
      chk("stream_valid", out_valid, 1);
    end

    // Stall with a second instruction offered
    out_ready = 0; in_instr = 32'h00A00113; in_pc = 32'h200;
    #1 chk("stall_ready", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_instr", out_instr, 32'h123450B7);
      chk("stall_pc", out_pc, 32'h110);
      chk("stall_valid", out_valid, 1);
      chk("stall_ready", in_ready, 0);
    end
    out_ready = 1;
    #1 chk("release_ready", in_ready, 1);
    @(negedge clk);
    chk("release_instr", out_instr, 32'h00A00113);
    chk("release_rd", out_rd, 2);
    in_valid = 0;

    // Illegal instruction and trap
    in_valid = 1; in_instr = 32'hFFFFFFFF; in_pc = 32'h300;
    @(negedge clk);
    chk("ill_flag", out_illegal, 1);
    chk("ill_ext", out_ext_sel, 3'b111);
    in_instr = 32'h00500093;
    #1 chk("trap_ready", in_ready, 0);
    @(negedge clk);
    chk("trap_drain", out_valid, 0);
    chk("trap_ready2", in_ready, 0);
    in_valid = 0; trap_ack = 1;
    @(negedge clk);
    trap_ack = 0;
    #1 chk("ack_ready", in_ready, 1);

    // flush + trap_ack while in TRAP_WAIT with a held instruction
    in_valid = 1; in_instr = 32'hFFFFFFFF; out_ready = 0;
    @(negedge clk);
    chk("held_ill", out_illegal, 1);
    chk("held_valid", out_valid, 1);
    flush = 1; trap_ack = 1; in_instr = 32'h00500093;
    #1 chk("flush_ready", in_ready, 0);
    @(negedge clk);
    flush = 0; trap_ack = 0; in_valid = 0;
    chk("flush_valid", out_valid, 0);
    chk("flush_nocap", out_instr, 32'hFFFFFFFF);
    #1 chk("flush_run", in_ready, 1);

    // fmadd.s
    out_ready = 1; in_valid = 1; in_instr = 32'h1820F0C3;
    @(negedge clk);
    in_valid = 0;
`ifdef RV32F_R4_DECODE_EN
    chk("r4_ext", out_ext_sel, 3'b101);
    chk("r4_rs3", out_rs3, 3);
    chk("r4_ill", out_illegal, 0);
    #1 chk("r4_ready", in_ready, 1);
`else
    chk("r4_ext", out_ext_sel, 3'b111);
    chk("r4_rs3", out_rs3, 0);
    chk("r4_ill", out_illegal, 1);
    #1 chk("r4_ready", in_ready, 0);
`endif
    trap_ack = 1;
    @(negedge clk);
    trap_ack = 0;

    // Asynchronous reset in the middle of a stall
    out_ready = 0; in_valid = 1; in_instr = 32'h00112223; in_pc = 32'h400;
    @(negedge clk);
    in_valid = 0;
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1;
    #1 chk("arst_valid", out_valid, 0);
    chk("arst_instr", out_instr, 32'h13);
    chk("arst_pc", out_pc, 0);
    @(negedge clk);
    rst = 0;

    // Randomized phase against the reference model
    m_valid = 0; m_ill = 0; m_trap = 0; m_instr = 32'h13; m_pc = 0;
    m_ext = 0; m_rs3 = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic exp_ready;
      int   f;
      chk("r_valid", out_valid, m_valid);
      chk("r_instr", out_instr, m_instr);
      chk("r_pc", out_pc, m_pc);
      chk("r_ext", out_ext_sel, m_ext);
      chk("r_ill", out_illegal, m_ill);
      chk("r_rs3", out_rs3, m_rs3);
      chk("r_fields", {out_rs1, out_rs2, out_rd},
          {m_instr[19:15], m_instr[24:20], m_instr[11:7]});

      in_valid  = ($urandom_range(9) < 7);
      out_ready = ($urandom_range(9) < 6);
      flush     = ($urandom_range(9) == 0);
      trap_ack  = ($urandom_range(9) < 2);
      in_pc     = $urandom;
      in_instr  = $urandom;
      if ($urandom_range(3) != 0)
        in_instr[6:0] = legal_ops[$urandom_range(legal_ops.size() - 1)];

      exp_ready = !m_trap && (!m_valid || out_ready) && !flush;
      #1 chk("r_ready", in_ready, exp_ready);

      f = ref_fmt(in_instr);
      if (m_trap && (trap_ack || flush)) m_trap = 0;
      if (flush) begin
        m_valid = 0;
      end else if (in_valid && exp_ready) begin
        m_valid = 1;
        m_instr = in_instr;
        m_pc    = in_pc;
        m_ill   = (f < 0);
        m_ext   = (f < 0) ? 3'b111 : 3'(f);
        m_rs3   = (f == 5) ? in_instr[31:27] : 5'd0;
        if (f < 0) m_trap = 1;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_decode_reg.md
Name: id_decode_reg

Overview:
- Decode-stage front end that sits between the IF/ID boundary and the immediate generator / register-file read.
- Accepts fetched instructions with a valid/ready handshake and classifies the opcode into the 3-bit immediate-format select (ext_sel) consumed by the immediate generator.
- Extracts register indices, flags illegal encodings, and registers everything into an ID output stage with stall and flush.
- A two-state trap FSM stops intake after an illegal instruction until the trap is acknowledged.

Parameters:
- XLEN, 32, instruction and PC width.
- RESET_PC, 32'h0000_0000, value loaded into out_pc on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_instr  in  XLEN  fetched instruction.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  registered decode result valid.
- out_ready  in  1  downstream (EX) accepts.
- out_instr  out  XLEN  registered instruction, feeds immediate generator instr.
- out_pc  out  XLEN  registered PC.
- out_ext_sel  out  3  immediate-format select, feeds immediate generator ext_sel.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_rs3  out  5  instr[31:27]; 0 unless R4 decoded.
- out_illegal  out  1  registered instruction is illegal.
- flush  in  1  kill held and incoming instruction (branch/trap redirect).
- trap_ack  in  1  trap handler has taken the illegal instruction.

Behaviour:
- ext_sel encoding:
  - 000 = I: OP-IMM 0010011, LOAD 0000011, JALR 1100111, SYSTEM 1110011, MISC-MEM 0001111.
  - 001 = S: 0100011.
  - 010 = B: 1100011.
  - 011 = J: 1101111.
  - 100 = U: LUI 0110111, AUIPC 0010111.
  - 101 = R4: feature only.
  - 111 = none: R-type 0110011.
- Illegal conditions:
  - instr[1:0] != 2'b11, or any opcode not listed above.
  - An illegal instruction gets ext_sel 111 and out_illegal = 1.
- Field extraction:
  - rs1 = instr[19:15], rs2 = instr[24:20], rd = instr[11:7], raw and unconditional.
  - Downstream qualifies these by ext_sel.
- Handshake and latency:
  - in_ready = (state == RUN) && (!out_valid || out_ready) && !flush.
  - Transfer occurs when in_valid && in_ready.
  - Latency is 1 cycle: the decode is registered on the transfer edge.
  - Back-to-back throughput is 1/cycle while out_ready = 1.
- Output register update per cycle, in priority order:
  - flush: out_valid <= 0; no capture.
  - else transfer: load all out_* and set out_valid <= 1.
  - else out_valid && out_ready: out_valid <= 0.
  - else hold.
- Stall: all out_* payload stays stable while out_valid && !out_ready.
- FSM states: RUN, TRAP_WAIT.
  - RUN -> TRAP_WAIT when an illegal instruction is transferred.
  - TRAP_WAIT -> RUN on trap_ack or flush.
  - The instruction already held in the output register still drains in TRAP_WAIT.
  - trap_ack in RUN is ignored.
- Simultaneous events:
  - flush together with a transfer attempt: flush wins, in_ready = 0, nothing is captured.
  - flush together with trap_ack: go to RUN.
- Reset (asynchronous):
  - out_valid = 0, out_illegal = 0, out_instr = 32'h0000_0013 (NOP).
  - out_pc = RESET_PC, out_ext_sel = 000, out_rs1/out_rs2/out_rd/out_rs3 = 0.
  - state = RUN.
  - Reset asserted mid-stall discards the held instruction.

Optional Feature:
- RV32F_R4_DECODE_EN
- Defined:
  - Opcodes 1000011, 1000111, 1001011, 1001111 (FMADD/FMSUB/FNMSUB/FNMADD) decode legal.
  - These get ext_sel 101 and out_rs3 = instr[31:27].
- Undefined:
  - Those opcodes are illegal and enter TRAP_WAIT.
  - out_rs3 is always 0 and ext_sel 101 is never produced.

Test Plan:
- Reset, then in_valid with instr 32'h00500093 (addi x1,x0,5), out_ready = 1 -> next cycle out_valid = 1, ext_sel = 000, rd = 1, rs1 = 0, out_illegal = 0.
- Stream sw 32'h00112223, beq 32'h00208463, jal 32'h008000EF, lui 32'h123450B7 back-to-back -> ext_sel 001, 010, 011, 100 on consecutive cycles with in_ready held at 1.
- Hold out_ready = 0 with out_valid = 1 and offer a second instruction -> in_ready = 0, payload unchanged for 5 cycles; release -> second instruction appears next cycle.
- Offer 32'hFFFFFFFF -> out_illegal = 1, ext_sel = 111, in_ready = 0 thereafter; pulse trap_ack -> in_ready = 1 the following cycle.
- Assert flush together with in_valid while out_valid = 1 -> next cycle out_valid = 0, nothing captured; the same cycle with trap_ack in TRAP_WAIT -> RUN.
- Offer 32'h1820F0C3 (fmadd.s) -> with macro: ext_sel 101, rs3 = 3, legal; without: out_illegal = 1 and TRAP_WAIT.
